// File: rtl/prco_mem_arbiter_pkg.sv
// Shared types and defaults for the local-memory arbiter.
package prco_mem_arbiter_pkg;

    // Requester tag carried alongside each memory command; NONE marks writes and idle slots.
    typedef enum logic [1:0] {
        PRCO_ARB_TAG_NONE = 2'd0,
        PRCO_ARB_TAG_F    = 2'd1,
        PRCO_ARB_TAG_D    = 2'd2,
        PRCO_ARB_TAG_H    = 2'd3
    } arb_tag_e;

    // Lock lifecycle: BLOCKED is entered after a forced release and lasts until D drops its lock.
    typedef enum logic [1:0] {
        LOCK_IDLE    = 2'd0,
        LOCK_HELD    = 2'd1,
        LOCK_BLOCKED = 2'd2
    } lock_state_e;

    localparam int unsigned PRCO_STARVE_MAX_DEF = 8;
    localparam int unsigned PRCO_LOCK_MAX_DEF   = 16;

endpackage

// File: rtl/prco_arb_tagpipe.sv
// Fixed-depth shift register of requester tags that tracks reads travelling through the memory.
module prco_arb_tagpipe
    import prco_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  arb_tag_e i_tag,
    output arb_tag_e q_tag
);

    arb_tag_e stage_q [DEPTH];
    arb_tag_e stage_d [DEPTH];

    // Shift the new tag in at the head and move every stage one step toward the tail.
    always_comb begin
        stage_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset empties the pipe so in-flight reads are forgotten.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= PRCO_ARB_TAG_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/prco_mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory between data (D), host (H) and fetch (F),
// with a fetch starvation guard, a bounded D lock and tagged read-data return.
module prco_mem_arbiter
    import prco_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = PRCO_STARVE_MAX_DEF,
    parameter int unsigned LOCK_MAX   = PRCO_LOCK_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              q_f_gnt,
    output logic              q_f_rvalid,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic              i_d_lock,
    output logic              q_d_gnt,
    output logic              q_d_rvalid,
    input  logic              i_h_req,
    input  logic              i_h_we,
    input  logic [ADDR_W-1:0] i_h_addr,
    input  logic [DATA_W-1:0] i_h_wdata,
    output logic              q_h_gnt,
    output logic              q_h_rvalid,
    output logic [DATA_W-1:0] q_rdata,
    output logic              q_mem_en,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [DATA_W-1:0] q_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic              q_lock_err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    lock_state_e   lock_state_q, lock_state_d;
    logic          lock_active, lock_final, starved;
    logic          f_gnt, d_gnt, h_gnt;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    arb_tag_e          mem_tag_q, mem_tag_d;
    arb_tag_e          ret_tag;

    assign starved    = (starve_cnt_q == SW'(STARVE_MAX));
    assign lock_final = (lock_cnt_q == LW'(LOCK_MAX - 1));

    // Grant selection: lock owner first, then a starved fetch, then D > H > F; nothing during reset.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!i_reset_n) begin
            f_gnt = 1'b0;
        end else if (lock_active) begin
            d_gnt = i_d_req;
        end else if (starved && i_f_req) begin
            f_gnt = 1'b1;
        end else if (i_d_req) begin
            d_gnt = 1'b1;
        end else if (i_h_req) begin
            h_gnt = 1'b1;
        end else if (i_f_req) begin
            f_gnt = 1'b1;
        end
    end

    // Count consecutive denied fetch cycles, frozen during a lock and saturating at the threshold.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_f_req || f_gnt) begin
            starve_cnt_d = '0;
        end else if (!lock_active && !starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Lock next state: a locked D transfer takes the lock, the timeout forces it into BLOCKED.
    always_comb begin
        lock_state_d = lock_state_q;
        case (lock_state_q)
            LOCK_IDLE:    if (d_gnt && i_d_lock) lock_state_d = LOCK_HELD;
            LOCK_HELD:    if (!i_d_lock) lock_state_d = LOCK_IDLE;
                          else if (lock_final) lock_state_d = LOCK_BLOCKED;
            LOCK_BLOCKED: if (!i_d_lock) lock_state_d = LOCK_IDLE;
            default:      lock_state_d = LOCK_IDLE;
        endcase
    end

    // Lock outputs and hold-time counter; the error flags the last permitted locked cycle.
    always_comb begin
        lock_active = (lock_state_q == LOCK_HELD);
        q_lock_err  = lock_active && i_d_lock && lock_final;
        lock_cnt_d  = (lock_active && i_d_lock && !lock_final) ? lock_cnt_q + 1'b1 : '0;
    end

    // Memory command for the winner; address and data hold when idle, reads carry a requester tag.
    always_comb begin
        mem_en_d   = f_gnt | d_gnt | h_gnt;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_tag_d  = PRCO_ARB_TAG_NONE;
        if (d_gnt) begin
            mem_we_d   = i_d_we;
            mem_addr_d = i_d_addr;
            mem_din_d  = i_d_wdata;
            mem_tag_d  = i_d_we ? PRCO_ARB_TAG_NONE : PRCO_ARB_TAG_D;
        end else if (h_gnt) begin
            mem_we_d   = i_h_we;
            mem_addr_d = i_h_addr;
            mem_din_d  = i_h_wdata;
            mem_tag_d  = i_h_we ? PRCO_ARB_TAG_NONE : PRCO_ARB_TAG_H;
        end else if (f_gnt) begin
            mem_addr_d = i_f_addr;
            mem_tag_d  = PRCO_ARB_TAG_F;
        end
    end

    // State and command registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            lock_state_q <= LOCK_IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_tag_q    <= PRCO_ARB_TAG_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_state_q <= lock_state_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_tag_q    <= mem_tag_d;
        end
    end

    prco_arb_tagpipe #(
        .DEPTH (MEM_LAT)
    ) u_tagpipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_tag     (mem_tag_q),
        .q_tag     (ret_tag)
    );

    assign q_f_gnt    = f_gnt;
    assign q_d_gnt    = d_gnt;
    assign q_h_gnt    = h_gnt;
    assign q_mem_en   = mem_en_q;
    assign q_mem_we   = mem_we_q;
    assign q_mem_addr = mem_addr_q;
    assign q_mem_din  = mem_din_q;
    assign q_f_rvalid = (ret_tag == PRCO_ARB_TAG_F);
    assign q_d_rvalid = (ret_tag == PRCO_ARB_TAG_D);
    assign q_h_rvalid = (ret_tag == PRCO_ARB_TAG_H);
    assign q_rdata    = i_reset_n ? i_mem_dout : '0;

endmodule

// File: tb/tb_prco_mem_arbiter.sv
// Directed bench for prco_mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3 share the
// same stimulus; read returns are scored against queues filled when grants are expected.
module tb_prco_mem_arbiter;

    typedef struct {
        logic [2:0]  tag;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic fReq = 1'b0, dReq = 1'b0, dWe = 1'b0, dLock = 1'b0, hReq = 1'b0, hWe = 1'b0;
    logic [15:0] fAddr = '0, dAddr = '0, dWdata = '0, hAddr = '0, hWdata = '0;

    logic fGnt1, fRv1, dGnt1, dRv1, hGnt1, hRv1, memEn1, memWe1, lockErr1;
    logic [15:0] rdata1, memAddr1, memDin1, memDout1;
    logic fGnt3, fRv3, dGnt3, dRv3, hGnt3, hRv3, memEn3, memWe3, lockErr3;
    logic [15:0] rdata3, memAddr3, memDin3, memDout3;
    logic [15:0] pipe3a, pipe3b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    prco_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(8), .LOCK_MAX(16)) dut (
        .i_clk(clk), .i_reset_n(rstN),
        .i_f_req(fReq), .i_f_addr(fAddr), .q_f_gnt(fGnt1), .q_f_rvalid(fRv1),
        .i_d_req(dReq), .i_d_we(dWe), .i_d_addr(dAddr), .i_d_wdata(dWdata), .i_d_lock(dLock),
        .q_d_gnt(dGnt1), .q_d_rvalid(dRv1),
        .i_h_req(hReq), .i_h_we(hWe), .i_h_addr(hAddr), .i_h_wdata(hWdata),
        .q_h_gnt(hGnt1), .q_h_rvalid(hRv1),
        .q_rdata(rdata1), .q_mem_en(memEn1), .q_mem_we(memWe1), .q_mem_addr(memAddr1),
        .q_mem_din(memDin1), .i_mem_dout(memDout1), .q_lock_err(lockErr1)
    );

    prco_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(8), .LOCK_MAX(16)) dut3 (
        .i_clk(clk), .i_reset_n(rstN),
        .i_f_req(fReq), .i_f_addr(fAddr), .q_f_gnt(fGnt3), .q_f_rvalid(fRv3),
        .i_d_req(dReq), .i_d_we(dWe), .i_d_addr(dAddr), .i_d_wdata(dWdata), .i_d_lock(dLock),
        .q_d_gnt(dGnt3), .q_d_rvalid(dRv3),
        .i_h_req(hReq), .i_h_we(hWe), .i_h_addr(hAddr), .i_h_wdata(hWdata),
        .q_h_gnt(hGnt3), .q_h_rvalid(hRv3),
        .q_rdata(rdata3), .q_mem_en(memEn3), .q_mem_we(memWe3), .q_mem_addr(memAddr3),
        .q_mem_din(memDin3), .i_mem_dout(memDout3), .q_lock_err(lockErr3)
    );

    // Read-only memory contents: every address returns a fixed pattern, 0x0005 holds 0xBEEF.
    function automatic logic [15:0] expData(input logic [15:0] a);
        return (a == 16'h0005) ? 16'hBEEF : (16'hC000 | a);
    endfunction

    // Memory models: data for the addressed word appears MEM_LAT cycles after the command cycle.
    always @(posedge clk) begin
        memDout1 <= expData(memAddr1);
        pipe3a   <= expData(memAddr3);
        pipe3b   <= pipe3a;
        memDout3 <= pipe3b;
    end

    function automatic logic [63:0] allOuts1();
        return {7'd0, fGnt1, fRv1, dGnt1, dRv1, hGnt1, hRv1, memEn1, memWe1, lockErr1,
                memAddr1, memDin1, rdata1};
    endfunction

    function automatic logic [63:0] allOuts3();
        return {7'd0, fGnt3, fRv3, dGnt3, dRv3, hGnt3, hRv3, memEn3, memWe3, lockErr3,
                memAddr3, memDin3, rdata3};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Drive one cycle of requests just after the falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic fr, input logic [15:0] fa,
                                 input logic dr, input logic dw, input logic [15:0] da,
                                 input logic [15:0] dd, input logic dl,
                                 input logic hr, input logic hw, input logic [15:0] ha,
                                 input logic [15:0] hd);
        @(negedge clk);
        #1;
        fReq = fr; fAddr = fa;
        dReq = dr; dWe = dw; dAddr = da; dWdata = dd; dLock = dl;
        hReq = hr; hWe = hw; hAddr = ha; hWdata = hd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Check grants of both instances and queue the read return a granted read must produce.
    task automatic checkGrants(input string name, input logic ef, input logic ed, input logic eh);
        exp_t e;
        #1;
        checkOutput(name, {58'd0, fGnt1, dGnt1, hGnt1, fGnt3, dGnt3, hGnt3},
                    {58'd0, ef, ed, eh, ef, ed, eh});
        e.tag = 3'b000;
        e.data = 16'h0;
        if (ef) begin e.tag = 3'b100; e.data = expData(fAddr); end
        else if (ed && !dWe) begin e.tag = 3'b010; e.data = expData(dAddr); end
        else if (eh && !hWe) begin e.tag = 3'b001; e.data = expData(hAddr); end
        if (e.tag != 3'b000) begin
            e.cyc = cyc + 2;
            q1.push_back(e);
            e.cyc = cyc + 4;
            q3.push_back(e);
        end
    endtask

    // Score read returns of the MEM_LAT=1 instance.
    always @(negedge clk) begin : mon1
        logic [2:0] obs, exp;
        exp_t e;
        obs = {fRv1, dRv1, hRv1};
        exp = 3'b000;
        e.data = 16'h0;
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            exp = e.tag;
        end
        if (exp != 3'b000 || obs != 3'b000) begin
            checkOutput("rvalid_lat1", {61'd0, obs}, {61'd0, exp});
            if (exp != 3'b000) checkOutput("rdata_lat1", {48'd0, rdata1}, {48'd0, e.data});
        end
    end

    // Score read returns of the MEM_LAT=3 instance.
    always @(negedge clk) begin : mon3
        logic [2:0] obs, exp;
        exp_t e;
        obs = {fRv3, dRv3, hRv3};
        exp = 3'b000;
        e.data = 16'h0;
        if (q3.size() > 0 && q3[0].cyc == cyc) begin
            e = q3.pop_front();
            exp = e.tag;
        end
        if (exp != 3'b000 || obs != 3'b000) begin
            checkOutput("rvalid_lat3", {61'd0, obs}, {61'd0, exp});
            if (exp != 3'b000) checkOutput("rdata_lat3", {48'd0, rdata3}, {48'd0, e.data});
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outs1", allOuts1(), 64'd0);
        checkOutput("reset_outs3", allOuts3(), 64'd0);
        rstN = 1'b1;

        // Single F read of 0x0005.
        applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        checkGrants("t1_gnt_f", 1'b1, 1'b0, 1'b0);
        idle();
        checkOutput("t1_mem_cmd", {47'd0, memEn1, memWe1, memAddr1}, {47'd0, 1'b1, 1'b0, 16'h0005});
        repeat (4) idle();

        // D write concurrent with F read: D first, then F.
        applyStimulus(1'b1, 16'h0002, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        checkGrants("t2_gnt_d", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        checkGrants("t2_gnt_f", 1'b1, 1'b0, 1'b0);
        checkOutput("t2_mem_wr", {30'd0, memEn1, memWe1, memAddr1, memDin1},
                    {30'd0, 1'b1, 1'b1, 16'h0010, 16'h1234});
        idle();
        checkOutput("t2_mem_rd", {47'd0, memEn1, memWe1, memAddr1}, {47'd0, 1'b1, 1'b0, 16'h0002});
        repeat (4) idle();

        // All three requesting: F breaks through on the 9th and 18th cycles.
        for (int i = 1; i <= 18; i++) begin
            applyStimulus(1'b1, 16'h0003, 1'b1, 1'b1, 16'h0080, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
            checkGrants("t3_starve_gnt", (i == 9 || i == 18), !(i == 9 || i == 18), 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
        checkGrants("t3_gnt_h", 1'b0, 1'b0, 1'b1);
        repeat (4) idle();

        // D lock held while H waits; forced release after 16 locked cycles.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0090, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0);
        checkGrants("t4_lock_take", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0);
            checkGrants("t4_locked_gnt", 1'b0, 1'b0, 1'b0);
            checkOutput("t4_lock_err", {63'd0, lockErr1}, {63'd0, (i == 16)});
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0);
        checkGrants("t4_h_after_release", 1'b0, 1'b0, 1'b1);
        checkOutput("t4_err_single", {62'd0, lockErr1, lockErr3}, 64'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0091, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0006, 16'h0);
        checkGrants("t4_relock_d", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0006, 16'h0);
        checkGrants("t4_relock_refused", 1'b0, 1'b0, 1'b1);
        idle();
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0092, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        checkGrants("t4_lock_again", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h0);
        checkGrants("t4_relocked_gnt", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0);
        checkGrants("t4_unlock_cycle", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0);
        checkGrants("t4_h_after_unlock", 1'b0, 1'b0, 1'b1);
        repeat (4) idle();

        // Alternating H/F reads back to back.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
                checkGrants("t5_gnt_h", 1'b0, 1'b0, 1'b1);
            end else begin
                applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                checkGrants("t5_gnt_f", 1'b1, 1'b0, 1'b0);
            end
        end
        repeat (6) idle();

        // Reset with reads in flight: outputs clear at once and the reads never return.
        applyStimulus(1'b1, 16'h0008, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        checkGrants("t6_gnt_f", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0009, 16'h0);
        checkGrants("t6_gnt_h", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h000A, 1'b1, 1'b0, 16'h000B, 16'h0, 1'b0, 1'b1, 1'b0, 16'h000C, 16'h0);
        rstN = 1'b0;
        q1.delete();
        q3.delete();
        #1;
        checkOutput("t6_reset_outs1", allOuts1(), 64'd0);
        checkOutput("t6_reset_outs3", allOuts3(), 64'd0);
        idle();
        idle();
        rstN = 1'b1;
        repeat (6) idle();
        applyStimulus(1'b1, 16'h000A, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        checkGrants("t6_post_reset_f", 1'b1, 1'b0, 1'b0);
        repeat (6) idle();

        checkOutput("queues_drained", 64'(q1.size() + q3.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prco_mem_arbiter.md
Name: prco_mem_arbiter

Overview:
- Shares the single-port local memory between three requesters, in fixed priority order:
  - D: data load/store from the ALU stage.
  - H: host loader fed from the UART.
  - F: instruction fetch.
- Uses a valid/grant handshake and registers the memory command.
- Tracks in-flight reads with a tag pipeline, so each read's data returns as an rvalid pulse to the requester that issued it.
- Adds a fetch starvation guard and a bounded data lock for atomic read-modify-write sequences.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, memory read latency in cycles (legal range 1..4).
- STARVE_MAX, 8, number of consecutive denied F cycles before F is promoted to top priority.
- LOCK_MAX, 16, maximum number of cycles a D lock may be held before forced release.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_f_req  in  1  fetch request.
- i_f_addr  in  ADDR_W  fetch address.
- q_f_gnt  out  1  fetch grant (combinational).
- q_f_rvalid  out  1  fetch read data valid.
- i_d_req  in  1  data request.
- i_d_we  in  1  data write enable.
- i_d_addr  in  ADDR_W  data address.
- i_d_wdata  in  DATA_W  data write data.
- i_d_lock  in  1  data lock request.
- q_d_gnt  out  1  data grant.
- q_d_rvalid  out  1  data read data valid.
- i_h_req  in  1  host request.
- i_h_we  in  1  host write enable.
- i_h_addr  in  ADDR_W  host address.
- i_h_wdata  in  DATA_W  host write data.
- q_h_gnt  out  1  host grant.
- q_h_rvalid  out  1  host read data valid.
- q_rdata  out  DATA_W  shared read data; i_mem_dout passed through.
- q_mem_en  out  1  memory command valid (registered).
- q_mem_we  out  1  memory write enable (registered).
- q_mem_addr  out  ADDR_W  memory address (registered).
- q_mem_din  out  DATA_W  memory write data (registered).
- i_mem_dout  in  DATA_W  memory read data.
- q_lock_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - A transfer occurs on the rising edge where req and gnt are both high.
  - The requester may present a new request in the following cycle.
- Grant is combinational from the current req inputs and the registered state (starve counter, lock state).
  - At most one gnt is high per cycle.
  - gnt is never high without the corresponding req.
- Priority, applied in order:
  1. Lock active: only D may be granted.
  2. Starved (starve_cnt == STARVE_MAX) and F requesting: F is granted.
  3. Otherwise D > H > F.
- Starve counter:
  - Increments each cycle i_f_req is high and q_f_gnt is low.
  - Saturates at STARVE_MAX.
  - Clears on an F transfer or when i_f_req is low.
  - Does not increment while the lock is active.
- Lock:
  - Set on a D transfer with i_d_lock high.
  - Cleared when i_d_lock is low; this may happen in any cycle.
  - While the lock is set, the lock counter increments each cycle. On reaching LOCK_MAX:
    - the lock clears;
    - q_lock_err pulses for 1 cycle;
    - further lock sets are blocked until i_d_lock has been observed low.
- Memory command:
  - On a transfer edge, q_mem_en=1 and addr/we/din are loaded from the winner.
  - Otherwise q_mem_en=0 and q_mem_we=0; addr and din hold their previous values.
  - Back-to-back transfers give one command per cycle, at full throughput.
- Read return:
  - A read transfer pushes a tag (F, D or H) into a MEM_LAT-deep shift pipe, aligned to the q_mem_en cycle.
  - The tag emerges MEM_LAT cycles after the command cycle and drives exactly one q_*_rvalid high for 1 cycle.
  - q_rdata = i_mem_dout in that cycle.
  - Request-accept edge to rvalid = 1 + MEM_LAT cycles.
  - Writes push an empty tag and produce no rvalid.
- Simultaneous requests: all three requesting every cycle with no lock gives D continuous grants. F is still granted on cycle STARVE_MAX+1, then the counter resets.
- Reset:
  - All q_* outputs go to 0, and q_mem_addr and q_mem_din go to 0.
  - Starve counter, lock state, lock counter and tag pipe are all cleared.
  - Reset mid-operation discards in-flight reads: no rvalid is produced after reset is released.
- Address and data pass through without arithmetic. The counters are clog2-sized and saturating, with no wrap-around.

Decomposition:
- inc/prco_constants.v gains:
  - requester tag defines PRCO_ARB_TAG_NONE/F/D/H (2-bit);
  - default STARVE_MAX and LOCK_MAX.
- One sub-module, prco_arb_tagpipe: a parameterised MEM_LAT-deep 2-bit tag shift register with async active-low clear. It outputs the emerging tag.

Test Plan:
- Single F read of addr 0x0005, memory returning 0xBEEF, MEM_LAT=1:
  - q_f_gnt is high in the request cycle;
  - q_mem_en/q_mem_addr=0x0005 appear the next cycle;
  - q_f_rvalid=1 with q_rdata=0xBEEF one cycle later;
  - q_d_rvalid and q_h_rvalid stay 0.
- D write 0x1234 to addr 0x0010 concurrent with F read of 0x0002:
  - D is granted first and produces q_mem_we=1 with din 0x1234;
  - F is granted the next cycle;
  - only q_f_rvalid pulses.
- D and H request continuously with F, STARVE_MAX=8:
  - F is granted exactly on the 9th cycle;
  - the counter resets;
  - F is granted again 9 cycles later.
- D lock held while H requests, LOCK_MAX=16:
  - H is not granted while the lock is active;
  - at cycle 16 q_lock_err pulses once and H is granted the next cycle;
  - D re-lock is refused until i_d_lock goes low.
- MEM_LAT=3 with alternating H/F reads of 0x0001/0x0002 back-to-back: rvalid order is H, F, H, F, each 4 cycles after its accept edge, with matching data.
- Assert i_reset_n low with two reads in flight: all outputs are 0 immediately, and no rvalid appears after reset is released.
